// File: rtl/program_sequencer.sv
// Program counter and sequencing unit: owns the PC, the start/done handshake,
// absolute/relative jumps and a bounded call/return stack with sticky error flags.
module program_sequencer #(
  parameter int unsigned PC_BITS     = 9,
  parameter int unsigned TARGET_BITS = 8,
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned NUM_DONE    = 2
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic [PC_BITS-1:0]           start_addr,
  input  logic [NUM_DONE*PC_BITS-1:0]  done_addr,
  input  logic                         next_ins,
  input  logic                         jump_flag,
  input  logic                         jump_mode,
  input  logic [TARGET_BITS-1:0]       target,
  input  logic                         call,
  input  logic                         ret,
  output logic [PC_BITS-1:0]           pc,
  output logic                         busy,
  output logic                         done,
  output logic                         stack_overflow,
  output logic                         stack_underflow
);

  localparam int unsigned SpBits  = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IdxBits = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e              r_state, w_state_next;
  logic [PC_BITS-1:0]  r_pc, w_pc_next;
  logic [SpBits-1:0]   r_sp, w_sp_next;
  logic [PC_BITS-1:0]  r_stack [STACK_DEPTH];
  logic                r_ovf, w_ovf_next;
  logic                r_unf, w_unf_next;
  logic                w_push;
  logic                w_done_hit;
  logic                w_full, w_empty;
  logic [IdxBits-1:0]  w_push_idx, w_pop_idx;
  logic [PC_BITS-1:0]  w_pc_inc, w_tgt_zext, w_tgt_sext, w_jump_pc;

  // Target narrower than the PC is extended; a wider one is truncated.
  if (TARGET_BITS >= PC_BITS) begin : g_trunc
    assign w_tgt_zext = target[PC_BITS-1:0];
    assign w_tgt_sext = target[PC_BITS-1:0];
  end else begin : g_ext
    assign w_tgt_zext = {{(PC_BITS-TARGET_BITS){1'b0}}, target};
    assign w_tgt_sext = {{(PC_BITS-TARGET_BITS){target[TARGET_BITS-1]}}, target};
  end

  assign w_pc_inc   = r_pc + 1'b1;
  assign w_jump_pc  = jump_mode ? (r_pc + w_tgt_sext) : w_tgt_zext;
  assign w_full     = (r_sp == SpBits'(STACK_DEPTH));
  assign w_empty    = (r_sp == '0);
  assign w_push_idx = IdxBits'(r_sp);
  assign w_pop_idx  = IdxBits'(r_sp - 1'b1);

  always_comb begin
    w_done_hit = 1'b0;
    for (int i = 0; i < int'(NUM_DONE); i++) begin
      if (r_pc == done_addr[i*PC_BITS +: PC_BITS]) w_done_hit = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= StIdle;
    else          r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    if (start) begin
      w_state_next = StRun;
    end else if (r_state == StRun && w_done_hit) begin
      w_state_next = StDone;
    end
  end

  // Output logic
  always_comb begin
    busy = (r_state == StRun);
    done = (r_state == StDone);
  end

  // Datapath: start dominates; a done hit freezes the PC for its final cycle.
  always_comb begin
    w_pc_next  = r_pc;
    w_sp_next  = r_sp;
    w_ovf_next = r_ovf;
    w_unf_next = r_unf;
    w_push     = 1'b0;
    if (start) begin
      w_pc_next  = start_addr;
      w_sp_next  = '0;
      w_ovf_next = 1'b0;
      w_unf_next = 1'b0;
    end else if (r_state == StRun && !w_done_hit && next_ins) begin
      if (ret) begin
        if (!w_empty) begin
          w_pc_next = r_stack[w_pop_idx];
          w_sp_next = r_sp - 1'b1;
        end else begin
          w_unf_next = 1'b1;
          w_pc_next  = w_pc_inc;
        end
      end else if (call) begin
        if (!w_full) begin
          w_push    = 1'b1;
          w_sp_next = r_sp + 1'b1;
        end else begin
          w_ovf_next = 1'b1;
        end
        w_pc_next = w_jump_pc;
      end else if (jump_flag) begin
        w_pc_next = w_jump_pc;
      end else begin
        w_pc_next = w_pc_inc;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pc  <= '0;
      r_sp  <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
      for (int i = 0; i < int'(STACK_DEPTH); i++) r_stack[i] <= '0;
    end else begin
      r_pc  <= w_pc_next;
      r_sp  <= w_sp_next;
      r_ovf <= w_ovf_next;
      r_unf <= w_unf_next;
      if (w_push) r_stack[w_push_idx] <= w_pc_inc;
    end
  end

  assign pc              = r_pc;
  assign stack_overflow  = r_ovf;
  assign stack_underflow = r_unf;

endmodule

// File: tb/tb_program_sequencer.sv
// Self-checking bench for program_sequencer: directed scenarios plus randomized
// traffic compared against a queue-based behavioural model.
module tb_program_sequencer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [8:0]  start_addr;
  logic [17:0] done_addr;
  logic        next_ins, jump_flag, jump_mode, call, ret;
  logic [7:0]  target;
  logic [8:0]  pc;
  logic        busy, done, stack_overflow, stack_underflow;

  int total = 0;
  int bad   = 0;

  // Behavioural model: 0 = idle, 1 = run, 2 = done
  int m_state;
  int m_pc;
  int m_stack[$];
  bit m_ovf, m_unf;

  program_sequencer #(
    .PC_BITS(9), .TARGET_BITS(8), .STACK_DEPTH(4), .NUM_DONE(2)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .start_addr(start_addr),
    .done_addr(done_addr), .next_ins(next_ins), .jump_flag(jump_flag),
    .jump_mode(jump_mode), .target(target), .call(call), .ret(ret), .pc(pc),
    .busy(busy), .done(done), .stack_overflow(stack_overflow),
    .stack_underflow(stack_underflow)
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    m_state = 0; m_pc = 0; m_stack.delete(); m_ovf = 0; m_unf = 0;
  endtask

  function automatic int jump_dest(int cur);
    int t;
    t = int'(target);
    if (!jump_mode) return t % 512;
    if (t >= 128) t -= 256;
    return (cur + t + 512) % 512;
  endfunction

  task automatic model_edge();
    bit hit;
    if (!reset_n) begin model_reset(); return; end
    if (start) begin
      m_state = 1; m_pc = int'(start_addr); m_stack.delete(); m_ovf = 0; m_unf = 0;
    end else if (m_state == 1) begin
      hit = (m_pc == int'(done_addr[8:0])) || (m_pc == int'(done_addr[17:9]));
      if (hit) m_state = 2;
      else if (next_ins) begin
        if (ret) begin
          if (m_stack.size() > 0) m_pc = m_stack.pop_back();
          else begin m_unf = 1; m_pc = (m_pc + 1) % 512; end
        end else if (call) begin
          if (m_stack.size() < 4) m_stack.push_back((m_pc + 1) % 512);
          else m_ovf = 1;
          m_pc = jump_dest(m_pc);
        end else if (jump_flag) m_pc = jump_dest(m_pc);
        else m_pc = (m_pc + 1) % 512;
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(bit ni, bit jf, bit jm, logic [7:0] tg, bit cl, bit rt);
    next_ins = ni; jump_flag = jf; jump_mode = jm; target = tg; call = cl; ret = rt;
  endtask

  task automatic do_start(logic [8:0] addr);
    drive(0, 0, 0, 8'd0, 0, 0);
    start = 1; start_addr = addr;
    tick();
    start = 0;
  endtask

  task automatic test_reset();
    reset_n = 1; start = 0; start_addr = '0; done_addr = '0;
    drive(0, 0, 0, 8'd0, 0, 0);
    #1 reset_n = 0;
    model_reset();
    #1;
    total++; if (pc !== 9'd0) begin bad++; $display("FAIL reset_pc got=%0d want=0", pc); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (stack_overflow !== 1'b0 || stack_underflow !== 1'b0) begin
      bad++; $display("FAIL reset_flags got=%b%b want=00", stack_overflow, stack_underflow);
    end
    @(posedge clock); #1;
    reset_n = 1;
    drive(1, 0, 0, 8'd0, 0, 0);
    tick(); tick();
    total++; if (pc !== 9'd0 || busy !== 1'b0) begin
      bad++; $display("FAIL idle_hold pc=%0d busy=%b want pc=0 busy=0", pc, busy);
    end
  endtask

  task automatic test_sequential();
    done_addr = {9'd511, 9'd435};
    do_start(9'd0);
    total++; if (pc !== 9'd0 || busy !== 1'b1 || done !== 1'b0) begin
      bad++; $display("FAIL seq_start pc=%0d busy=%b done=%b want 0/1/0", pc, busy, done);
    end
    drive(1, 0, 0, 8'd0, 0, 0);
    for (int k = 1; k <= 435; k++) begin
      tick();
      total++; if (pc !== 9'(k) || busy !== 1'b1) begin
        bad++; $display("FAIL seq_count pc=%0d busy=%b want pc=%0d busy=1", pc, busy, k);
      end
    end
    tick();
    total++; if (done !== 1'b1 || busy !== 1'b0 || pc !== 9'd435) begin
      bad++; $display("FAIL seq_done pc=%0d done=%b busy=%b want 435/1/0", pc, done, busy);
    end
    tick();
    total++; if (pc !== 9'd435 || done !== 1'b1) begin
      bad++; $display("FAIL seq_frozen pc=%0d done=%b want 435/1", pc, done);
    end
  endtask

  task automatic test_rel_jump();
    done_addr = {9'd401, 9'd400};
    do_start(9'd10);
    drive(1, 1, 1, 8'hFC, 0, 0);
    tick();
    total++; if (pc !== 9'd6) begin bad++; $display("FAIL rel_back pc=%0d want=6", pc); end
    do_start(9'd2);
    drive(1, 1, 1, 8'hFC, 0, 0);
    tick();
    total++; if (pc !== 9'd510) begin bad++; $display("FAIL rel_wrap pc=%0d want=510", pc); end
    drive(0, 1, 0, 8'd33, 1, 1);
    tick();
    total++; if (pc !== 9'd510) begin bad++; $display("FAIL hold_no_next pc=%0d want=510", pc); end
  endtask

  task automatic test_call_ret();
    done_addr = {9'd401, 9'd400};
    do_start(9'd20);
    drive(1, 0, 0, 8'd100, 1, 0);
    tick();
    total++; if (pc !== 9'd100) begin bad++; $display("FAIL call_abs pc=%0d want=100", pc); end
    drive(1, 0, 0, 8'd0, 0, 1);
    tick();
    total++; if (pc !== 9'd21) begin bad++; $display("FAIL ret_pop pc=%0d want=21", pc); end
    drive(1, 0, 0, 8'd50, 1, 0);
    tick();
    drive(1, 0, 0, 8'd90, 1, 1);
    tick();
    total++; if (pc !== 9'd22) begin bad++; $display("FAIL call_ret_same pc=%0d want=22", pc); end
    drive(1, 0, 0, 8'd0, 0, 1);
    tick();
    total++; if (pc !== 9'd23 || stack_underflow !== 1'b1) begin
      bad++; $display("FAIL no_push pc=%0d unf=%b want 23/1", pc, stack_underflow);
    end
  endtask

  task automatic test_stack_errors();
    logic [8:0] exp_ret [5];
    exp_ret = '{9'd31, 9'd21, 9'd11, 9'd1, 9'd2};
    done_addr = {9'd401, 9'd400};
    do_start(9'd0);
    for (int i = 1; i <= 5; i++) begin
      drive(1, 0, 0, 8'(10 * i), 1, 0);
      tick();
      total++; if (pc !== 9'(10 * i) || stack_overflow !== (i == 5)) begin
        bad++; $display("FAIL call_nest%0d pc=%0d ovf=%b want %0d/%0d", i, pc, stack_overflow,
                        10 * i, i == 5);
      end
    end
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 8'd0, 0, 1);
      tick();
      total++; if (pc !== exp_ret[i] || stack_underflow !== (i == 4)) begin
        bad++; $display("FAIL ret_nest%0d pc=%0d unf=%b want %0d/%0d", i, pc, stack_underflow,
                        exp_ret[i], i == 4);
      end
    end
    do_start(9'd3);
    total++; if (stack_overflow !== 1'b0 || stack_underflow !== 1'b0 || pc !== 9'd3) begin
      bad++; $display("FAIL flags_clear ovf=%b unf=%b pc=%0d want 0/0/3", stack_overflow,
                      stack_underflow, pc);
    end
  endtask

  task automatic test_reset_mid_run();
    done_addr = {9'd401, 9'd400};
    do_start(9'd200);
    tick();
    total++; if (pc !== 9'd200 || busy !== 1'b1) begin
      bad++; $display("FAIL pre_reset pc=%0d busy=%b want 200/1", pc, busy);
    end
    #2 reset_n = 0;
    model_reset();
    #1;
    total++; if (pc !== 9'd0 || busy !== 1'b0) begin
      bad++; $display("FAIL async_reset pc=%0d busy=%b want 0/0", pc, busy);
    end
    @(posedge clock); #1;
    reset_n = 1;
    drive(1, 1, 0, 8'd77, 0, 0);
    tick(); tick(); tick();
    total++; if (pc !== 9'd0 || busy !== 1'b0) begin
      bad++; $display("FAIL post_reset_idle pc=%0d busy=%b want 0/0", pc, busy);
    end
  endtask

  task automatic test_restart();
    done_addr = {9'd401, 9'd400};
    do_start(9'd75);
    drive(1, 0, 0, 8'd0, 0, 1);
    tick();
    drive(1, 0, 1, 8'd1, 1, 0);
    tick();
    total++; if (pc !== 9'd77 || stack_underflow !== 1'b1) begin
      bad++; $display("FAIL restart_setup pc=%0d unf=%b want 77/1", pc, stack_underflow);
    end
    drive(1, 0, 0, 8'd0, 0, 0);
    start = 1; start_addr = 9'd5;
    tick();
    start = 0;
    total++; if (pc !== 9'd5 || busy !== 1'b1 || stack_underflow !== 1'b0) begin
      bad++; $display("FAIL restart pc=%0d busy=%b unf=%b want 5/1/0", pc, busy, stack_underflow);
    end
    drive(1, 0, 0, 8'd0, 0, 1);
    tick();
    total++; if (pc !== 9'd6 || stack_underflow !== 1'b1) begin
      bad++; $display("FAIL restart_empty pc=%0d unf=%b want 6/1", pc, stack_underflow);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      start = (n == 0) || ($urandom_range(0, 24) == 0);
      if (start) begin
        start_addr = 9'($urandom);
        done_addr  = {9'($urandom), 9'(start_addr + 9'($urandom_range(0, 20)))};
      end
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, 1'($urandom),
            8'($urandom), $urandom_range(0, 5) == 0, $urandom_range(0, 6) == 0);
      tick();
      total++; if (pc !== 9'(m_pc)) begin
        bad++; $display("FAIL rand_pc cycle=%0d got=%0d want=%0d", n, pc, m_pc);
      end
      total++; if (busy !== (m_state == 1) || done !== (m_state == 2)) begin
        bad++; $display("FAIL rand_state cycle=%0d busy=%b done=%b want state=%0d", n, busy, done,
                        m_state);
      end
      total++; if (stack_overflow !== m_ovf || stack_underflow !== m_unf) begin
        bad++; $display("FAIL rand_flags cycle=%0d got=%b%b want=%b%b", n, stack_overflow,
                        stack_underflow, m_ovf, m_unf);
      end
    end
    start = 0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_rel_jump();
    test_call_ret();
    test_stack_errors();
    test_reset_mid_run();
    test_restart();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/program_sequencer.md
# program_sequencer

Parametrised next-generation program counter and sequencing unit for the single-cycle core. It owns the PC, the start/done handshake and all control-flow updates. Over the current counter it adds:

- a configurable PC width;
- multiple done addresses;
- absolute and PC-relative jumps;
- a hardware call/return stack with sticky error flags;
- an explicit IDLE/RUN/DONE state machine.

It drives the instruction memory address and takes its jump target from the ALU output.

## Interface
- PC_BITS, 9, width of the PC and of all address ports
- TARGET_BITS, 8, width of the ALU-supplied jump target
- STACK_DEPTH, 4, return-stack entries (≥1)
- NUM_DONE, 2, number of done addresses compared (≥1)

- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  synchronous pulse; begins or restarts a program
- start_addr  input  PC_BITS  PC loaded on start
- done_addr  input  NUM_DONE*PC_BITS  packed done addresses; entry i at bits [i*PC_BITS +: PC_BITS]
- next_ins  input  1  advance enable from control
- jump_flag  input  1  branch taken, from the ALU
- jump_mode  input  1  0 = absolute target, 1 = PC-relative target
- target  input  TARGET_BITS  jump target or offset
- call  input  1  push return address and jump
- ret  input  1  pop return address
- pc  output  PC_BITS  current instruction address
- busy  output  1  high in RUN
- done  output  1  high in DONE
- stack_overflow  output  1  sticky; a call was made with the stack full
- stack_underflow  output  1  sticky; a ret was made with the stack empty

## Operation

**States**

- IDLE: pc holds; busy = 0; done = 0. start → RUN.
- RUN: busy = 1; pc updates as below.
- DONE: done = 1; pc frozen. start → RUN.

**Start.** start in any state loads pc = start_addr, empties the stack and clears both sticky flags. Start in RUN is a restart.

**Done detection.** In RUN, if pc equals any done_addr entry, the next edge enters DONE. This takes priority over any pc update in that cycle.

**PC update in RUN when next_ins = 1** (priority order):

1. ret:
   - stack non-empty: pc = popped value.
   - stack empty: set stack_underflow; pc = pc+1.
   - A call asserted in the same cycle is ignored.
2. call:
   - Push pc+1 (mod 2^PC_BITS), then jump using jump_mode; jump_flag is not required.
   - Stack full: set stack_overflow, discard the push, still jump.
3. jump_flag:
   - jump_mode = 0: pc = target zero-extended, or truncated, to PC_BITS.
   - jump_mode = 1: pc = pc + sign-extended target, mod 2^PC_BITS.
4. Otherwise: pc = pc+1, wrapping from 2^PC_BITS−1 to 0.

**When next_ins = 0:** pc holds, and call, ret and jump_flag are ignored.

**Stack.** LIFO with an occupancy counter from 0 to STACK_DEPTH. Push and pop never occur in the same cycle.

## Timing
- Reset (asynchronous, reset_n = 0): state IDLE; pc = 0; busy = 0; done = 0; stack_overflow = 0; stack_underflow = 0; stack empty. All outputs take these values immediately, independent of clock.
- Reset mid-RUN: the same values take effect immediately; the sequencer stays in IDLE until a start pulse after reset_n rises.
- All outputs are registered and update on the rising clock edge.
- start sampled at edge N: pc = start_addr and busy = 1 after edge N.
- pc update latency is one cycle: inputs sampled at edge N, new pc visible after edge N.
- pc matches a done address before edge N: done = 1 and busy = 0 after edge N.
- The done address itself is never advanced past.
- Sticky flags are set at the edge of the offending instruction and cleared only by start or reset.

## Test plan
- Sequential run: reset; start with start_addr = 0 and done_addr = {435, 511}; hold next_ins = 1 → pc counts 0…435. done = 1 the cycle after pc = 435, with pc held at 435.
- Relative jump: pc = 10, jump_mode = 1, target = 8'hFC → pc = 6. Repeat at pc = 2 with target = 8'hFC → pc = 510 (wrap).
- Call/return: pc = 20, call with absolute target 100 → pc = 100. Then ret → pc = 21. call and ret in the same cycle at pc = 50 → pop taken, no push.
- Stack errors: five nested calls with STACK_DEPTH = 4 → stack_overflow = 1 and the 5th jump still taken. Five rets → the 5th sets stack_underflow = 1 with pc = pc+1. Both flags clear on start.
- Reset mid-run: in RUN at pc = 200, pull reset_n low between edges → pc = 0 and busy = 0 immediately. No movement until the next start.
- Restart: start asserted in RUN at pc = 77 with start_addr = 5 → pc = 5 next cycle, stack empty, flags clear.
